// File: rtl/multi_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// multi_cycle_sequencer
//   Multi-cycle instruction sequencer.
//   It fetches an instruction word, decodes its 6-bit opcode (ir[31:26]),
//   walks through the EXEC/MEM/WB phases that the opcode needs, and then
//   retires it by updating pc and instret.
//   An illegal opcode parks the FSM in TRAP until reset.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   run            level enable for leaving IDLE / continuing after retirement
//   instr_rdata    instruction word, captured in FETCH when instr_valid=1
//   instr_valid    instruction memory ready
//   data_ready     data memory finished the current access (sampled in MEM)
//   branch_taken   condition result for the latched BRANCH/CALL
//   branch_target  destination used when the latched branch is taken
//   pc             program counter
//   ir             instruction register
//   instr_req      high in FETCH
//   data_req       high in MEM
//   data_we        high in MEM for STORE
//   regfile_we     high in WB
//   pc_we          one-cycle pulse in the cycle after a retirement edge
//   busy           high in every state except IDLE and TRAP
//   trap           high while parked in TRAP
//   instret        retired-instruction counter (wraps)
//   state          IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7
// -----------------------------------------------------------------------------
module multi_cycle_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] PC_RESET = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [31:0]         instr_rdata,
    input  logic                instr_valid,
    input  logic                data_ready,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         ir,
    output logic                instr_req,
    output logic                data_req,
    output logic                data_we,
    output logic                regfile_we,
    output logic                pc_we,
    output logic                busy,
    output logic                trap,
    output logic [31:0]         instret,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    // Opcode classification helpers
    function automatic logic is_alu_op(input logic [5:0] op);
        return (op == 6'd32) || (op == 6'd0) || (op == 6'd1);
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == 6'd2);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == 6'd3);
    endfunction

    // BRANCH spans 4..15; CALL (14) is a branch that also writes back
    function automatic logic is_branch_op(input logic [5:0] op);
        return (op >= 6'd4) && (op <= 6'd15);
    endfunction

    function automatic logic is_call_op(input logic [5:0] op);
        return (op == 6'd14);
    endfunction

    state_t                state_r;
    state_t                next_state_s;
    logic [PC_WIDTH-1:0]   pc_r;
    logic [31:0]           ir_r;
    logic [31:0]           instret_r;
    logic                  take_q_r;
    logic                  pc_we_r;
    logic                  take_next_s;
    logic                  retire_s;
    logic                  ir_load_s;
    logic [5:0]            opcode_s;
    state_t                retire_dest_s;

    assign opcode_s      = ir_r[31:26];
    assign retire_dest_s = run ? S_FETCH : S_IDLE;

    // Next-state and retirement decision
    always_comb begin
        next_state_s = state_r;
        take_next_s  = take_q_r;
        retire_s     = 1'b0;
        ir_load_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (instr_valid) begin
                    ir_load_s    = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_alu_op(opcode_s) || is_load_op(opcode_s) ||
                    is_store_op(opcode_s) || is_branch_op(opcode_s)) begin
                    next_state_s = S_EXEC;
                end else begin
                    next_state_s = S_TRAP;
                end
            end
            S_EXEC: begin
                // take_q only ever holds a branch condition; cleared otherwise
                take_next_s = is_branch_op(opcode_s) ? branch_taken : 1'b0;
                if (is_alu_op(opcode_s) || is_call_op(opcode_s)) begin
                    next_state_s = S_WB;
                end else if (is_load_op(opcode_s) || is_store_op(opcode_s)) begin
                    next_state_s = S_MEM;
                end else begin
                    retire_s     = 1'b1;
                    next_state_s = retire_dest_s;
                end
            end
            S_MEM: begin
                if (!data_ready) begin
                    next_state_s = S_MEM;
                end else if (is_load_op(opcode_s)) begin
                    next_state_s = S_WB;
                end else begin
                    retire_s     = 1'b1;
                    next_state_s = retire_dest_s;
                end
            end
            S_WB: begin
                retire_s     = 1'b1;
                next_state_s = retire_dest_s;
            end
            S_TRAP: begin
                next_state_s = S_TRAP;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State, architectural registers and the retirement pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            pc_r      <= PC_RESET;
            ir_r      <= 32'd0;
            instret_r <= 32'd0;
            take_q_r  <= 1'b0;
            pc_we_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            take_q_r <= take_next_s;
            pc_we_r  <= retire_s;
            if (ir_load_s) begin
                ir_r <= instr_rdata;
            end
            if (retire_s) begin
                // In EXEC take_next_s is the live condition; elsewhere it is take_q
                pc_r      <= take_next_s ? branch_target : (pc_r + PC_WIDTH'(4));
                instret_r <= instret_r + 32'd1;
            end
        end
    end

    // Strobes are decoded from registered state (and the latched ir) only
    assign instr_req  = (state_r == S_FETCH);
    assign data_req   = (state_r == S_MEM);
    assign data_we    = (state_r == S_MEM) && is_store_op(opcode_s);
    assign regfile_we = (state_r == S_WB);
    assign busy       = (state_r != S_IDLE) && (state_r != S_TRAP);
    assign trap       = (state_r == S_TRAP);
    assign pc_we      = pc_we_r;
    assign pc         = pc_r;
    assign ir         = ir_r;
    assign instret    = instret_r;
    assign state      = state_r;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
module tb_multi_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] instr_rdata;
    logic        instr_valid;
    logic        data_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        instr_req;
    logic        data_req;
    logic        data_we;
    logic        regfile_we;
    logic        pc_we;
    logic        busy;
    logic        trap;
    logic [31:0] instret;
    logic [2:0]  state;

    int n_vec = 0;
    int n_bad = 0;

    multi_cycle_sequencer #(.PC_WIDTH(32), .PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .run(run), .instr_rdata(instr_rdata),
        .instr_valid(instr_valid), .data_ready(data_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .ir(ir), .instr_req(instr_req), .data_req(data_req),
        .data_we(data_we), .regfile_we(regfile_we), .pc_we(pc_we),
        .busy(busy), .trap(trap), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    // advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; instr_rdata = 32'd0; instr_valid = 1'b0;
        data_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        repeat (3) step();
        n_vec++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_vec++; if (pc !== 32'd0 || ir !== 32'd0 || instret !== 32'd0) begin
            n_bad++; $display("FAIL reset_regs: pc=%h ir=%h instret=%h expected all 0", pc, ir, instret); end
        n_vec++; if ({instr_req, data_req, data_we, regfile_we, pc_we, busy, trap} !== 7'd0) begin
            n_bad++; $display("FAIL reset_strobes: got %b expected 0000000",
                              {instr_req, data_req, data_we, regfile_we, pc_we, busy, trap}); end
    endtask

    // ALU add: FETCH, DECODE, EXEC, WB, then retire to IDLE
    task automatic test_alu();
        logic [2:0] exp_st [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0};
        int rf = 0, pw = 0;
        rst = 1'b0; run = 1'b1; instr_valid = 1'b1; instr_rdata = 32'h8000_0000;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) run = 1'b0;
            if (i == 1) begin
                n_vec++; if (ir !== 32'h8000_0000) begin n_bad++; $display("FAIL alu_ir: got %h expected 80000000", ir); end
            end
            n_vec++; if (state !== exp_st[i]) begin n_bad++; $display("FAIL alu_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
            rf += int'(regfile_we); pw += int'(pc_we);
        end
        n_vec++; if (rf != 1 || pw != 1) begin n_bad++; $display("FAIL alu_pulses: regfile_we=%0d pc_we=%0d expected 1 1", rf, pw); end
        n_vec++; if (pc !== 32'h4 || instret !== 32'd1) begin n_bad++; $display("FAIL alu_retire: pc=%h instret=%0d expected 4 1", pc, instret); end
    endtask

    // LOAD with data_ready on the 4th MEM cycle
    task automatic test_load();
        int mem = 0, dr = 0, dw = 0, rf = 0, pw = 0;
        run = 1'b1; instr_rdata = 32'h0800_0000;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) run = 1'b0;
            if (state == 3'd4) begin mem++; data_ready = (mem == 4); end else data_ready = 1'b0;
            if (i == 7) begin
                n_vec++; if (state !== 3'd5) begin n_bad++; $display("FAIL load_wb: got state %0d expected 5", state); end
            end
            dr += int'(data_req); dw += int'(data_we); rf += int'(regfile_we); pw += int'(pc_we);
        end
        n_vec++; if (dr != 4 || dw != 0) begin n_bad++; $display("FAIL load_mem: data_req=%0d data_we=%0d expected 4 0", dr, dw); end
        n_vec++; if (rf != 1 || pw != 1) begin n_bad++; $display("FAIL load_pulses: regfile_we=%0d pc_we=%0d expected 1 1", rf, pw); end
        n_vec++; if (pc !== 32'h8 || instret !== 32'd2) begin n_bad++; $display("FAIL load_retire: pc=%h instret=%0d expected 8 2", pc, instret); end
    endtask

    // taken BRANCH opcode 5; 3-cycle instruction without write-back
    task automatic test_branch(input logic [31:0] target, input logic [31:0] exp_instret);
        int rf = 0, pw = 0;
        run = 1'b1; instr_rdata = 32'h1400_0000; branch_taken = 1'b1; branch_target = target;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) run = 1'b0;
            if (i == 3) begin
                n_vec++; if (state !== 3'd0 || pc_we !== 1'b1) begin
                    n_bad++; $display("FAIL branch_retire_cycle: state=%0d pc_we=%b expected 0 1", state, pc_we); end
            end
            rf += int'(regfile_we); pw += int'(pc_we);
        end
        n_vec++; if (rf != 0 || pw != 1) begin n_bad++; $display("FAIL branch_pulses: regfile_we=%0d pc_we=%0d expected 0 1", rf, pw); end
        n_vec++; if (pc !== target || instret !== exp_instret) begin
            n_bad++; $display("FAIL branch_pc: pc=%h instret=%0d expected %h %0d", pc, instret, target, exp_instret); end
    endtask

    // ALU at 0xFFFFFFFC wraps pc; branch_taken stays high and must be ignored
    task automatic test_pc_wrap();
        test_branch(32'hFFFF_FFFC, 32'd4);
        run = 1'b1; instr_rdata = 32'h8000_0000; branch_taken = 1'b1; branch_target = 32'h0000_0ABC;
        for (int i = 0; i < 6; i++) begin step(); if (i == 0) run = 1'b0; end
        n_vec++; if (pc !== 32'h0 || instret !== 32'd5) begin n_bad++; $display("FAIL pc_wrap: pc=%h instret=%0d expected 0 5", pc, instret); end
    endtask

    // CALL (14) goes through WB and takes the branch at retirement
    task automatic test_call();
        int rf = 0;
        run = 1'b1; instr_rdata = 32'h3800_0000; branch_taken = 1'b1; branch_target = 32'h200;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) run = 1'b0;
            if (i == 3) begin
                n_vec++; if (state !== 3'd5) begin n_bad++; $display("FAIL call_wb: got state %0d expected 5", state); end
            end
            rf += int'(regfile_we);
        end
        branch_taken = 1'b0;
        n_vec++; if (rf != 1 || pc !== 32'h200 || instret !== 32'd6) begin
            n_bad++; $display("FAIL call_retire: rf=%0d pc=%h instret=%0d expected 1 200 6", rf, pc, instret); end
    endtask

    // two ALU instructions with run held high: retire goes straight to FETCH
    task automatic test_back_to_back();
        run = 1'b1; instr_rdata = 32'h0400_0000;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 4) begin
                n_vec++; if (state !== 3'd1) begin n_bad++; $display("FAIL b2b_refetch: got state %0d expected 1", state); end
            end
            if (i == 7) run = 1'b0;
        end
        n_vec++; if (state !== 3'd0 || pc !== 32'h208 || instret !== 32'd8) begin
            n_bad++; $display("FAIL b2b_retire: state=%0d pc=%h instret=%0d expected 0 208 8", state, pc, instret); end
    endtask

    // run dropped while a STORE waits in MEM
    task automatic test_store_run_drop();
        int dw = 0;
        run = 1'b1; instr_rdata = 32'h0C00_0000;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 3) run = 1'b0;
            data_ready = (i == 4);
            dw += int'(data_we);
            if (i == 5) begin
                n_vec++; if (state !== 3'd0 || busy !== 1'b0 || pc_we !== 1'b1) begin
                    n_bad++; $display("FAIL store_drop_retire: state=%0d busy=%b pc_we=%b expected 0 0 1", state, busy, pc_we); end
            end
        end
        n_vec++; if (dw != 2 || state !== 3'd0 || pc !== 32'h20C || instret !== 32'd9) begin
            n_bad++; $display("FAIL store_drop_final: data_we=%0d state=%0d pc=%h instret=%0d expected 2 0 20c 9", dw, state, pc, instret); end
    endtask

    // preload instret to all-ones, then one retirement wraps it
    task automatic test_instret_wrap();
        force dut.instret_r = 32'hFFFF_FFFF;
        step();
        release dut.instret_r;
        step();
        n_vec++; if (instret !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL instret_preload: got %h expected ffffffff", instret); end
        run = 1'b1; instr_rdata = 32'h8000_0000;
        for (int i = 0; i < 6; i++) begin step(); if (i == 0) run = 1'b0; end
        n_vec++; if (instret !== 32'd0 || pc !== 32'h210) begin n_bad++; $display("FAIL instret_wrap: instret=%h pc=%h expected 0 210", instret, pc); end
    endtask

    // reset in the middle of MEM kills strobes immediately and retires nothing
    task automatic test_reset_mid_mem();
        run = 1'b1; instr_rdata = 32'h0800_0000; data_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); if (i == 0) run = 1'b0; end
        n_vec++; if (data_req !== 1'b1) begin n_bad++; $display("FAIL rst_mem_pre: data_req=%b expected 1", data_req); end
        rst = 1'b1;
        #1;
        n_vec++; if (data_req !== 1'b0 || busy !== 1'b0 || state !== 3'd0 || pc !== 32'd0 || instret !== 32'd0) begin
            n_bad++; $display("FAIL rst_mem_async: data_req=%b busy=%b state=%0d pc=%h instret=%0d expected 0 0 0 0 0",
                              data_req, busy, state, pc, instret); end
        step();
        rst = 1'b0;
        repeat (2) step();
        n_vec++; if (pc_we !== 1'b0 || instret !== 32'd0 || state !== 3'd0) begin
            n_bad++; $display("FAIL rst_mem_after: pc_we=%b instret=%0d state=%0d expected 0 0 0", pc_we, instret, state); end
    endtask

    // illegal opcode 20 parks in TRAP until reset
    task automatic test_trap();
        run = 1'b1; instr_rdata = 32'h5000_0000;
        step(); run = 1'b0;
        step();
        n_vec++; if (state !== 3'd2) begin n_bad++; $display("FAIL trap_decode: got state %0d expected 2", state); end
        step();
        n_vec++; if (state !== 3'd7 || trap !== 1'b1) begin n_bad++; $display("FAIL trap_enter: state=%0d trap=%b expected 7 1", state, trap); end
        run = 1'b1; data_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++; if (trap !== 1'b1 || busy !== 1'b0 || {instr_req, data_req, data_we, regfile_we, pc_we} !== 5'd0 ||
                         pc !== 32'd0 || instret !== 32'd0 || ir !== 32'h5000_0000) begin
                n_bad++; $display("FAIL trap_hold[%0d]: trap=%b busy=%b pc=%h instret=%0d ir=%h expected 1 0 0 0 50000000",
                                  i, trap, busy, pc, instret, ir); end
        end
        run = 1'b0; data_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (trap !== 1'b0 || state !== 3'd0 || ir !== 32'd0) begin
            n_bad++; $display("FAIL trap_clear: trap=%b state=%0d ir=%h expected 0 0 0", trap, state, ir); end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch(32'h100, 32'd3);
        test_pc_wrap();
        test_call();
        test_back_to_back();
        test_store_run_drop();
        test_instret_wrap();
        test_reset_mid_mem();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
